// File: rtl/sync_fifo_param_if.sv
// Write/read handshake, status and error bundle for sync_fifo_param.
// master = the FIFO user, slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: simple dual-port RAM with registered read,
// occupancy counter, registered status flags and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL    = (ADDR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              full_reg, full_next;
  logic              empty_reg, empty_next;
  logic              almost_full_reg, almost_full_next;
  logic              almost_empty_reg, almost_empty_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;
  logic              rd_acc, wr_acc;

  // A full FIFO may still take a write when a pop frees a slot at the same edge.
  assign rd_acc = bus.rd_en & ~empty_reg;
  assign wr_acc = bus.wr_en & (~full_reg | rd_acc);

  always_comb begin
    wr_ptr_next = wr_acc ? wr_ptr_reg + ADDR_W'(1) : wr_ptr_reg;
    rd_ptr_next = rd_acc ? rd_ptr_reg + ADDR_W'(1) : rd_ptr_reg;

    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + (ADDR_W + 1)'(1);
      2'b01:   count_next = count_reg - (ADDR_W + 1)'(1);
      default: count_next = count_reg;
    endcase

    full_next         = (count_next == DEPTH_CNT);
    empty_next        = (count_next == '0);
    almost_full_next  = (count_next >= AF_LVL);
    almost_empty_next = (count_next <= AE_LVL);

    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_next  = bus.clr_err ? 1'b0 : overflow_reg;
    underflow_next = bus.clr_err ? 1'b0 : underflow_reg;
    if (bus.wr_en & ~wr_acc)   overflow_next  = 1'b1;
    if (bus.rd_en & empty_reg) underflow_next = 1'b1;
  end

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (rd_acc) begin
        rd_data_reg <= mem[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      full_reg         <= full_next;
      empty_reg        <= empty_next;
      almost_full_reg  <= almost_full_next;
      almost_empty_reg <= almost_empty_next;
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
    end
  end

  assign bus.rd_data      = rd_data_reg;
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_full  = almost_full_reg;
  assign bus.almost_empty = almost_empty_reg;
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule
